// File: rtl/data_mem_port.sv
// rtl/data_mem_port.sv - MEM-stage load/store responder: request handshake, byte lanes, load extension.
// Holds the pipeline while a single data-memory access is outstanding.
module data_mem_port #(
   parameter int unsigned MAX_WAIT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_i,
   input  logic        mem_read_i,
   input  logic        mem_write_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        data_read,
   output logic        data_write,
   output logic [31:0] data_addr,
   output logic [3:0]  data_mbe,
   output logic [31:0] data_wdata,
   input  logic        data_resp,
   input  logic [31:0] data_rdata,
   output logic        stall_o,
   output logic        done_o,
   output logic [31:0] load_data_o,
   output logic        misaligned_o,
   output logic        err_o
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

   localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

   state_t      r_state;
   state_t      w_next;
   logic [7:0]  r_wait_cnt;
   logic        r_is_read;
   logic [2:0]  r_funct3;
   logic [1:0]  r_off;

   logic        w_req;
   logic        w_misaligned;
   logic        w_accept;
   logic        w_timeout;
   logic [3:0]  w_mbe;
   logic [31:0] w_wdata;
   logic [31:0] w_shifted;
   logic [31:0] w_load;

   assign w_req     = valid_i & (mem_read_i | mem_write_i);
   assign w_timeout = (r_wait_cnt == WAIT_LAST);

   always_comb begin
      w_misaligned = 1'b0;
      case (funct3_i)
         3'b001, 3'b101: w_misaligned = addr_i[0];
         3'b010:         w_misaligned = |addr_i[1:0];
         default:        w_misaligned = 1'b0;
      endcase
   end

   // Lane placement for stores; reads always fetch the whole word.
   always_comb begin
      w_mbe   = 4'b1111;
      w_wdata = wdata_i;
      if (mem_read_i) begin
         w_mbe   = 4'b1111;
         w_wdata = 32'h0;
      end else begin
         case (funct3_i)
            3'b000, 3'b100: begin
               w_mbe   = 4'b0001 << addr_i[1:0];
               w_wdata = {4{wdata_i[7:0]}};
            end
            3'b001, 3'b101: begin
               w_mbe   = 4'b0011 << addr_i[1:0];
               w_wdata = {2{wdata_i[15:0]}};
            end
            default: begin
               w_mbe   = 4'b1111;
               w_wdata = wdata_i;
            end
         endcase
      end
   end

   assign w_shifted = data_rdata >> {r_off, 3'b000};

   always_comb begin
      w_load = data_rdata;
      case (r_funct3)
         3'b000:  w_load = {{24{w_shifted[7]}}, w_shifted[7:0]};
         3'b100:  w_load = {24'h0, w_shifted[7:0]};
         3'b001:  w_load = {{16{w_shifted[15]}}, w_shifted[15:0]};
         3'b101:  w_load = {16'h0, w_shifted[15:0]};
         default: w_load = data_rdata;
      endcase
   end

   always_comb begin
      w_next       = r_state;
      w_accept     = 1'b0;
      stall_o      = 1'b0;
      misaligned_o = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_req) begin
               if (w_misaligned) begin
                  misaligned_o = 1'b1;
               end else begin
                  w_accept = 1'b1;
                  stall_o  = 1'b1;
                  w_next   = S_REQ;
               end
            end
         end
         S_REQ: begin
            stall_o = 1'b1;
            if (data_resp || w_timeout) begin
               w_next = S_RESP;
            end
         end
         S_RESP:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
      // Combinational outputs follow reset immediately, like the registered ones.
      if (rst) begin
         stall_o      = 1'b0;
         misaligned_o = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wait_cnt  <= 8'h0;
         r_is_read   <= 1'b0;
         r_funct3    <= 3'b000;
         r_off       <= 2'b00;
         data_read   <= 1'b0;
         data_write  <= 1'b0;
         data_addr   <= 32'h0;
         data_mbe    <= 4'h0;
         data_wdata  <= 32'h0;
         done_o      <= 1'b0;
         err_o       <= 1'b0;
         load_data_o <= 32'h0;
      end else begin
         done_o <= 1'b0;
         err_o  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_is_read  <= mem_read_i;
                  r_funct3   <= funct3_i;
                  r_off      <= addr_i[1:0];
                  r_wait_cnt <= 8'h0;
                  data_read  <= mem_read_i;
                  data_write <= ~mem_read_i;
                  data_addr  <= {addr_i[31:2], 2'b00};
                  data_mbe   <= w_mbe;
                  data_wdata <= w_wdata;
               end
            end
            S_REQ: begin
               if (data_resp || w_timeout) begin
                  data_read   <= 1'b0;
                  data_write  <= 1'b0;
                  data_addr   <= 32'h0;
                  data_mbe    <= 4'h0;
                  data_wdata  <= 32'h0;
                  done_o      <= 1'b1;
                  err_o       <= ~data_resp;
                  load_data_o <= (data_resp && r_is_read) ? w_load : 32'h0;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 8'h1;
               end
            end
            S_RESP: begin
               r_wait_cnt  <= 8'h0;
               load_data_o <= 32'h0;
            end
            default: begin
               r_wait_cnt <= 8'h0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_port.sv
// tb/tb_data_mem_port.sv - scoreboard bench for data_mem_port with directed load/store vectors.
module tb_data_mem_port;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_i, mem_read_i, mem_write_i;
   logic [2:0]  funct3_i;
   logic [31:0] addr_i, wdata_i;
   logic        data_read, data_write;
   logic [31:0] data_addr;
   logic [3:0]  data_mbe;
   logic [31:0] data_wdata;
   logic        data_resp;
   logic [31:0] data_rdata;
   logic        stall_o, done_o, misaligned_o, err_o;
   logic [31:0] load_data_o;

   always #5 clk = ~clk;

   data_mem_port #(.MAX_WAIT(4)) dut (
      .clk(clk), .rst(rst), .valid_i(valid_i), .mem_read_i(mem_read_i),
      .mem_write_i(mem_write_i), .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i),
      .data_read(data_read), .data_write(data_write), .data_addr(data_addr),
      .data_mbe(data_mbe), .data_wdata(data_wdata), .data_resp(data_resp),
      .data_rdata(data_rdata), .stall_o(stall_o), .done_o(done_o),
      .load_data_o(load_data_o), .misaligned_o(misaligned_o), .err_o(err_o)
   );

   typedef struct packed {
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [3:0]  mbe;
      logic [31:0] wdata;
   } req_t;

   typedef struct packed {
      logic [31:0] data;
      logic        err;
      logic [7:0]  cycles;
   } resp_t;

   req_t  req_q[$];
   resp_t resp_q[$];
   int    n_vec = 0;
   int    n_fail = 0;
   int    req_cycles = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: request fields every active cycle, response on done_o.
   initial begin
      resp_t r;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (data_read | data_write) begin
               req_cycles++;
               if (req_q.size() == 0) begin
                  n_vec++; n_fail++;
                  $display("FAIL unexpected_req: got rd=%b wr=%b expected no request", data_read, data_write);
               end else begin
                  chk("req_rd", 32'(data_read), 32'(req_q[0].rd));
                  chk("req_wr", 32'(data_write), 32'(req_q[0].wr));
                  chk("req_addr", data_addr, req_q[0].addr);
                  chk("req_mbe", 32'(data_mbe), 32'(req_q[0].mbe));
                  chk("req_wdata", data_wdata, req_q[0].wdata);
               end
            end
            if (done_o) begin
               if (resp_q.size() == 0) begin
                  n_vec++; n_fail++;
                  $display("FAIL unexpected_done: got done_o=1 expected no completion");
               end else begin
                  r = resp_q.pop_front();
                  chk("load_data", load_data_o, r.data);
                  chk("err", 32'(err_o), 32'(r.err));
                  chk("req_cycles", 32'(req_cycles), 32'(r.cycles));
                  if (req_q.size() != 0) void'(req_q.pop_front());
               end
               req_cycles = 0;
            end
         end
      end
   end

   task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input int delay, input logic [31:0] rdata,
                         input logic [3:0] exp_mbe, input logic [31:0] exp_wdata,
                         input logic [31:0] exp_data, input logic exp_err,
                         input int exp_cyc, input bit late);
      int  cyc;
      bit  got;
      req_t  q;
      resp_t s;
      q.rd = rd; q.wr = wr & ~rd; q.addr = {addr[31:2], 2'b00}; q.mbe = exp_mbe; q.wdata = exp_wdata;
      s.data = exp_data; s.err = exp_err; s.cycles = 8'(exp_cyc);
      req_q.push_back(q);
      resp_q.push_back(s);
      @(negedge clk);
      valid_i = 1'b1; mem_read_i = rd; mem_write_i = wr; funct3_i = f3; addr_i = addr; wdata_i = wd;
      #1 chk("accept_stall", 32'(stall_o), 32'd1);
      @(negedge clk);
      valid_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0;
      cyc = 0;
      got = 1'b0;
      for (int k = 0; k < 300 && !got; k++) begin
         cyc++;
         if (cyc == delay) begin
            data_resp = 1'b1;
            data_rdata = rdata;
         end
         @(negedge clk);
         data_resp = 1'b0;
         if (done_o) got = 1'b1;
      end
      chk("done_seen", 32'(got), 32'd1);
      chk("resp_stall", 32'(stall_o), 32'd0);
      if (late) begin
         data_resp = 1'b1;
         data_rdata = 32'hFFFF_FFFF;
         @(negedge clk);
         data_resp = 1'b0;
         chk("late_resp_done", 32'(done_o), 32'd0);
         chk("late_resp_req", 32'(data_read | data_write), 32'd0);
      end else begin
         @(negedge clk);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      valid_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0; funct3_i = 3'b000;
      addr_i = 32'h0; wdata_i = 32'h0; data_resp = 1'b0; data_rdata = 32'h0;
      repeat (2) @(negedge clk);
      chk("rst_data_read", 32'(data_read), 32'd0);
      chk("rst_data_write", 32'(data_write), 32'd0);
      chk("rst_data_addr", data_addr, 32'h0);
      chk("rst_data_mbe", 32'(data_mbe), 32'h0);
      chk("rst_stall", 32'(stall_o), 32'd0);
      chk("rst_done", 32'(done_o), 32'd0);
      chk("rst_load", load_data_o, 32'h0);
      chk("rst_err", 32'(err_o), 32'd0);
      rst = 1'b0;

      //      rd    wr    f3      addr          wdata         dly rdata         mbe      exp_wdata     exp_data      err  cyc late
      access(1'b1, 1'b0, 3'b010, 32'h1000_0008, 32'h0,        2, 32'hDEAD_BEEF, 4'b1111, 32'h0,        32'hDEAD_BEEF, 1'b0, 2, 1'b0);
      access(1'b1, 1'b0, 3'b000, 32'h1000_0003, 32'h0,        1, 32'h80AA_BBCC, 4'b1111, 32'h0,        32'hFFFF_FF80, 1'b0, 1, 1'b0);
      access(1'b1, 1'b0, 3'b100, 32'h1000_0003, 32'h0,        1, 32'h80AA_BBCC, 4'b1111, 32'h0,        32'h0000_0080, 1'b0, 1, 1'b0);
      access(1'b1, 1'b0, 3'b101, 32'h1000_0002, 32'h0,        1, 32'h80AA_BBCC, 4'b1111, 32'h0,        32'h0000_80AA, 1'b0, 1, 1'b0);
      access(1'b1, 1'b0, 3'b001, 32'h1000_0002, 32'h0,        1, 32'h80AA_BBCC, 4'b1111, 32'h0,        32'hFFFF_80AA, 1'b0, 1, 1'b0);
      access(1'b1, 1'b0, 3'b000, 32'h1000_0001, 32'h0,        3, 32'h80AA_BBCC, 4'b1111, 32'h0,        32'hFFFF_FFBB, 1'b0, 3, 1'b0);
      access(1'b0, 1'b1, 3'b001, 32'h1000_0002, 32'h1234_5678, 1, 32'hAAAA_AAAA, 4'b1100, 32'h5678_5678, 32'h0,        1'b0, 1, 1'b0);
      access(1'b0, 1'b1, 3'b000, 32'h1000_0001, 32'h0000_00AB, 2, 32'h0,        4'b0010, 32'hABAB_ABAB, 32'h0,        1'b0, 2, 1'b0);

      // Misaligned word load: suppressed in IDLE.
      @(negedge clk);
      valid_i = 1'b1; mem_read_i = 1'b1; mem_write_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h1000_0001;
      #1;
      chk("misaligned_pulse", 32'(misaligned_o), 32'd1);
      chk("misaligned_stall", 32'(stall_o), 32'd0);
      @(negedge clk);
      valid_i = 1'b0; mem_read_i = 1'b0;
      #1;
      chk("misaligned_no_read", 32'(data_read), 32'd0);
      chk("misaligned_clear", 32'(misaligned_o), 32'd0);

      // Store timeout with MAX_WAIT=4, then a late response that must be ignored.
      access(1'b0, 1'b1, 3'b010, 32'h2000_0004, 32'hCAFE_F00D, 0, 32'h0,        4'b1111, 32'hCAFE_F00D, 32'h0,        1'b1, 4, 1'b1);

      // Reset while a read is outstanding.
      begin
         req_t q;
         q.rd = 1'b1; q.wr = 1'b0; q.addr = 32'h1000_0020; q.mbe = 4'b1111; q.wdata = 32'h0;
         req_q.push_back(q);
      end
      @(negedge clk);
      valid_i = 1'b1; mem_read_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h1000_0020;
      @(negedge clk);
      valid_i = 1'b0; mem_read_i = 1'b0;
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midreq_rst_read", 32'(data_read), 32'd0);
      chk("midreq_rst_stall", 32'(stall_o), 32'd0);
      req_q.delete();
      resp_q.delete();
      req_cycles = 0;
      @(negedge clk);
      rst = 1'b0;

      access(1'b1, 1'b0, 3'b010, 32'h1000_0010, 32'h0,        1, 32'h0123_4567, 4'b1111, 32'h0,        32'h0123_4567, 1'b0, 1, 1'b0);
      access(1'b1, 1'b1, 3'b010, 32'h1000_0014, 32'h0000_0055, 1, 32'h0765_4321, 4'b1111, 32'h0,        32'h0765_4321, 1'b0, 1, 1'b0);

      repeat (3) @(negedge clk);
      chk("resp_q_drained", 32'(resp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
